// File: rtl/bist_pkg.sv
// Shared types and helpers for the LFSR/MISR built-in self-test engine.
// The top-level abort input is enabled by defining BIST_ABORT_EN.
package bist_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_e;

    // Default feedback mask for a given width; other widths fall back to the 8-bit mask.
    function automatic logic [WIDTH_MAX-1:0] default_taps(input int unsigned w);
        logic [WIDTH_MAX-1:0] t;
        case (w)
            4:       t = WIDTH_MAX'(TAPS_W4);
            16:      t = WIDTH_MAX'(TAPS_W16);
            default: t = WIDTH_MAX'(TAPS_W8);
        endcase
        return t;
    endfunction

    function automatic logic parity_fb(input logic [WIDTH_MAX-1:0] state,
                                       input logic [WIDTH_MAX-1:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One shift step of a Fibonacci LFSR with optional parallel input (MISR when din != 0).
module lfsr_step
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] next
);

    logic fb;

    assign fb   = parity_fb(WIDTH_MAX'(state), WIDTH_MAX'(TAPS));
    assign next = {state[WIDTH-2:0], fb} ^ din;

endmodule

// File: rtl/bist_lfsr_misr.sv
// BIST engine: LFSR pattern generator, MISR response compactor and run-control FSM.
// Define BIST_ABORT_EN to add the abort input.
module bist_lfsr_misr
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH         = 8,
    parameter logic [WIDTH-1:0] TAPS          = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED          = WIDTH'(1),
    parameter int unsigned      PATTERN_COUNT = 16,
    parameter logic [WIDTH-1:0] GOLDEN_SIG    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef BIST_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] pattern_out,
    input  logic [WIDTH-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature,
    output logic             pass
);

    localparam int unsigned CNT_W = $clog2(64'(PATTERN_COUNT) + 64'd1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("bist_lfsr_misr: WIDTH out of range 2..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("bist_lfsr_misr: SEED must be non-zero");
    end
    if (PATTERN_COUNT == 0 ||
        64'(PATTERN_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_count
        $error("bist_lfsr_misr: PATTERN_COUNT out of range 1..2**WIDTH-1");
    end

    bist_state_e      state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] lfsr_nx, misr_nx;
    logic             abort_w;

`ifdef BIST_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr (
        .state (lfsr_q),
        .din   ('0),
        .next  (lfsr_nx)
    );

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_misr (
        .state (misr_q),
        .din   (resp_in),
        .next  (misr_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            misr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            count_q <= count_d;
        end
    end

    // Run control: each RUN cycle absorbs the response to the pattern currently driven.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        count_d = count_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    lfsr_d  = SEED;
                    misr_d  = '0;
                    count_d = '0;
                end
            end
            RUN: begin
                if (abort_w) begin
                    state_d = IDLE;
                    misr_d  = '0;
                    count_d = '0;
                end else begin
                    lfsr_d  = lfsr_nx;
                    misr_d  = misr_nx;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(PATTERN_COUNT - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign pattern_out = busy ? lfsr_q : '0;
    assign signature   = misr_q;
    assign pass        = done && (misr_q == GOLDEN_SIG);

endmodule

// File: tb/tb_bist_lfsr_misr.sv
// Self-checking bench for bist_lfsr_misr: table vectors, randomized runs against a
// behavioural model, and hand-written restart/reset/PATTERN_COUNT=1 sequences.
module tb_bist_lfsr_misr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start1;
    logic [3:0] resp4;
    logic [3:0] pat4, sig4;
    logic       busy4, done4, pass4;
    logic [7:0] pat1, sig1, resp1;
    logic       busy1, done1, pass1;
`ifdef BIST_ABORT_EN
    logic       abort4 = 1'b0;
    logic       abort1 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bist_lfsr_misr #(
        .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .PATTERN_COUNT(4), .GOLDEN_SIG(4'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start4),
`ifdef BIST_ABORT_EN
        .abort(abort4),
`endif
        .pattern_out(pat4), .resp_in(resp4), .busy(busy4), .done(done4),
        .signature(sig4), .pass(pass4)
    );

    // Single-pattern instance; its CUT is pattern ^ 8'h3C, so the golden value is 5A ^ 3C.
    assign resp1 = pat1 ^ 8'h3C;

    bist_lfsr_misr #(
        .WIDTH(8), .TAPS(8'hB8), .SEED(8'h5A), .PATTERN_COUNT(1), .GOLDEN_SIG(8'h66)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef BIST_ABORT_EN
        .abort(abort1),
`endif
        .pattern_out(pat1), .resp_in(resp1), .busy(busy1), .done(done1),
        .signature(sig1), .pass(pass1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model step: shift left by doubling, feedback is the parity of the tapped bits, then XOR input.
    function automatic logic [3:0] m_step(input logic [3:0] x, input logic [3:0] d);
        int v;
        v = (int'(x) * 2) % 16 + ($countones(x & 4'hC) % 2);
        return 4'(v) ^ d;
    endfunction

    logic [3:0] resp_seq [4];
    logic       rand_start = 1'b0;

    // One full run of dut from IDLE/DONE; leaves the DUT one cycle into DONE.
    task automatic do_run(input string tag);
        logic [3:0] pat, sig;
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        pat = 4'h1;
        sig = 4'h0;
        for (int k = 0; k < 4; k++) begin
            check({tag, " busy"}, 32'(busy4), 32'd1);
            check({tag, " done_low"}, 32'(done4), 32'd0);
            check({tag, " pattern"}, 32'(pat4), 32'(pat));
            check({tag, " sig_run"}, 32'(sig4), 32'(sig));
            resp4 = resp_seq[k];
            if (rand_start) start4 = 1'($urandom_range(0, 1));
            sig = m_step(sig, resp_seq[k]);
            pat = m_step(pat, 4'h0);
            @(negedge clk);
        end
        start4 = 1'b0;
        check({tag, " done"}, 32'(done4), 32'd1);
        check({tag, " busy_low"}, 32'(busy4), 32'd0);
        check({tag, " pattern_idle"}, 32'(pat4), 32'd0);
        check({tag, " signature"}, 32'(sig4), 32'(sig));
        check({tag, " pass"}, 32'(pass4), 32'(sig == 4'h0));
        resp4 = 4'($urandom);
        @(negedge clk);
        check({tag, " done_hold"}, 32'(done4), 32'd1);
        check({tag, " sig_hold"}, 32'(sig4), 32'(sig));
    endtask

    typedef struct {
        logic [3:0] resp_first;
        logic [3:0] exp_sig;
        logic       exp_pass;
    } vec_t;

    vec_t vt [4];

    initial begin
        logic [3:0] s;
        vt[0] = '{resp_first: 4'h0, exp_sig: 4'h0, exp_pass: 1'b1};
        vt[1] = '{resp_first: 4'h1, exp_sig: 4'h9, exp_pass: 1'b0};
        vt[2] = '{resp_first: 4'h2, exp_sig: 4'h3, exp_pass: 1'b0};
        vt[3] = '{resp_first: 4'h8, exp_sig: 4'h4, exp_pass: 1'b0};

        rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0; resp4 = 4'h0;
        #1;
        check("rst pattern", 32'(pat4), 32'd0);
        check("rst busy", 32'(busy4), 32'd0);
        check("rst done", 32'(done4), 32'd0);
        check("rst sig", 32'(sig4), 32'd0);
        check("rst pass", 32'(pass4), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle busy", 32'(busy4), 32'd0);
        check("idle done", 32'(done4), 32'd0);

        // Table: a response only on the first pattern, known final signatures.
        for (int i = 0; i < 4; i++) begin
            resp_seq[0] = vt[i].resp_first;
            for (int k = 1; k < 4; k++) resp_seq[k] = 4'h0;
            do_run($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d exp_sig", i), 32'(sig4), 32'(vt[i].exp_sig));
            check($sformatf("tbl%0d exp_pass", i), 32'(pass4), 32'(vt[i].exp_pass));
        end

        // Random responses with start toggling during RUN (must be ignored).
        rand_start = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) resp_seq[k] = 4'($urandom);
            do_run($sformatf("rnd%0d", r));
        end
        rand_start = 1'b0;

        // Start held high: DONE lasts one cycle and the next run restarts cleanly.
        @(negedge clk); resp4 = 4'h1; start4 = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        s = 4'h0;
        for (int k = 0; k < 4; k++) s = m_step(s, 4'h1);
        check("held done", 32'(done4), 32'd1);
        check("held sig", 32'(sig4), 32'(s));
        @(negedge clk);
        check("held restart busy", 32'(busy4), 32'd1);
        check("held restart done", 32'(done4), 32'd0);
        check("held restart pattern", 32'(pat4), 32'd1);
        check("held restart sig", 32'(sig4), 32'd0);
        start4 = 1'b0;
        repeat (4) @(negedge clk);
        check("held second done", 32'(done4), 32'd1);
        check("held second sig", 32'(sig4), 32'(s));

        // Single-pattern instance.
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        check("pc1 busy", 32'(busy1), 32'd1);
        check("pc1 pattern", 32'(pat1), 32'h5A);
        check("pc1 done_low", 32'(done1), 32'd0);
        @(negedge clk);
        check("pc1 done", 32'(done1), 32'd1);
        check("pc1 sig", 32'(sig1), 32'h66);
        check("pc1 pass", 32'(pass1), 32'd1);
        check("pc1 busy_low", 32'(busy1), 32'd0);
        @(negedge clk);
        check("pc1 done_hold", 32'(done1), 32'd1);

        // Asynchronous reset during the third RUN cycle.
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0; resp4 = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst busy", 32'(busy4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async pattern", 32'(pat4), 32'd0);
        check("async busy", 32'(busy4), 32'd0);
        check("async done", 32'(done4), 32'd0);
        check("async sig", 32'(sig4), 32'd0);
        check("async pass", 32'(pass4), 32'd0);
        check("async pc1 sig", 32'(sig1), 32'd0);
        check("async pc1 done", 32'(done1), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            resp4 = 4'($urandom);
            @(negedge clk);
            check("post_rst done", 32'(done4), 32'd0);
            check("post_rst busy", 32'(busy4), 32'd0);
            check("post_rst sig", 32'(sig4), 32'd0);
        end

`ifdef BIST_ABORT_EN
        // Abort on the second RUN cycle returns to IDLE with a cleared signature.
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0; resp4 = 4'hF;
        @(negedge clk); abort4 = 1'b1;
        @(negedge clk); abort4 = 1'b0;
        check("abort busy", 32'(busy4), 32'd0);
        check("abort done", 32'(done4), 32'd0);
        check("abort sig", 32'(sig4), 32'd0);
        check("abort pattern", 32'(pat4), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort no_done", 32'(done4), 32'd0);
        end
`endif

        // One more clean run after all corner cases.
        for (int k = 0; k < 4; k++) resp_seq[k] = 4'($urandom);
        do_run("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected summary");
        $fatal(1, "timeout");
    end

endmodule
